rom_arbiter: RTL and testbench

Shares one synchronous graphics/program ROM (the `sprom` macro: registered read, active-low enable, one-cycle latency) between up to `NUM_REQ` requesters, typically video tile fetch, sprite fetch and the CPU. It accepts at most one read per cycle, drives the ROM address and enable, and tracks which requester owns each in-flight read. It returns the ROM data to that requester with a one-cycle valid strobe. The block sits between the requesters and the ROM instance, and is the only driver of the ROM's enable and address.

---
 rtl/rom_arbiter_pkg.sv | 19 +
 rtl/rom_arbiter_if.sv | 29 ++
 rtl/rom_arbiter_rr_pick.sv | 43 ++++
 rtl/rom_arbiter.sv | 151 +++++++++++++++
 tb/tb_rom_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared constants and helpers for the ROM arbiter slice.
package rom_arb_pkg;

  // Read latency of the sprom macro (registered output).
  localparam int ROM_LAT = 1;
  // Cycles from ack to rd_valid.
  localparam int ARB_LAT = 3;
  // Largest requester count the owner-id encoding supports.
  localparam int MAX_REQ = 8;

  // Expand a 3-bit owner id into a one-hot vector of MAX_REQ bits.
  function automatic logic [MAX_REQ-1:0] id_to_onehot(input logic [2:0] id);
    logic [MAX_REQ-1:0] oh;
    oh = {MAX_REQ{1'b0}};
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side and ROM-side bus of the ROM arbiter.
// The arbiter uses the slave modport; requesters/ROM model use master.
interface rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 15,
  parameter int DW      = 8
);
  import rom_arb_pkg::*;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] addr;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    rd_valid;
  logic [DW-1:0]         rd_data;
  logic                  rom_ena_n;
  logic [AW-1:0]         rom_address;
  logic [DW-1:0]         rom_q;

  modport slave (
    input  req, addr, rom_q,
    output ack, rd_valid, rd_data, rom_ena_n, rom_address
  );

  modport master (
    output req, addr, rom_q,
    input  ack, rd_valid, rd_data, rom_ena_n, rom_address
  );

endinterface

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first requester at or
// after the pointer (wrapping) wins.
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic          w_found;
  logic [IW:0]   w_pos;

  // Scan N positions starting at the pointer and take the first requester.
  always_comb begin
    w_found = 1'b0;
    w_pos   = {(IW+1){1'b0}};
    o_grant = {N{1'b0}};
    o_idx   = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N)) begin
        w_pos = w_pos - (IW+1)'(N);
      end else begin
        w_pos = w_pos;
      end
      if (!w_found && i_mask[w_pos[IW-1:0]]) begin
        w_found                  = 1'b1;
        o_grant[w_pos[IW-1:0]]   = 1'b1;
        o_idx                    = w_pos[IW-1:0];
      end else begin
        w_found = w_found;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM between NUM_REQ requesters: one read per
// cycle, optional fixed priority for requester 0, three-stage owner tracking
// so each read's data returns to the requester that issued it.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = 15,
  parameter int DW      = 8,
  parameter int PRIO0   = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  rom_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Arbitration signals
  logic [NUM_REQ-1:0] w_rr_mask;
  logic [NUM_REQ-1:0] w_rr_grant;
  logic [IW-1:0]      w_rr_idx;
  logic               w_rr_any;
  logic               w_prio_hit;
  logic               w_rr_fire;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_win_idx;
  logic               w_any_grant;
  logic [IW-1:0]      w_ptr_next;
  logic [AW-1:0]      w_win_addr;

  // Registered state
  logic [IW-1:0]      r_ptr;
  logic               r_s1_v;
  logic [IW-1:0]      r_s1_id;
  logic               r_s2_v;
  logic [IW-1:0]      r_s2_id;
  logic [NUM_REQ-1:0] r_rd_valid;
  logic [DW-1:0]      r_rd_data;
  logic               r_rom_ena_n;
  logic [AW-1:0]      r_rom_address;

  // Requester 0 is taken out of the round-robin pool when it has priority.
  assign w_rr_mask  = (PRIO0 != 0) ? (bus.req & ~NUM_REQ'(1)) : bus.req;
  assign w_prio_hit = (PRIO0 != 0) && bus.req[0];

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_mask  (w_rr_mask),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  // Final winner: nothing in reset, then requester-0 override, then round-robin.
  always_comb begin
    w_grant   = {NUM_REQ{1'b0}};
    w_win_idx = {IW{1'b0}};
    if (!reset_n) begin
      w_grant   = {NUM_REQ{1'b0}};
      w_win_idx = {IW{1'b0}};
    end else if (w_prio_hit) begin
      w_grant   = NUM_REQ'(1);
      w_win_idx = {IW{1'b0}};
    end else begin
      w_grant   = w_rr_grant;
      w_win_idx = w_rr_idx;
    end
  end

  assign w_any_grant = |w_grant;
  assign w_rr_fire   = reset_n && !w_prio_hit && w_rr_any;
  assign w_win_addr  = bus.addr[w_win_idx*AW +: AW];

  // Next pointer: slot after the round-robin winner; wraps past requester 0
  // when it is served by the priority path instead.
  always_comb begin
    w_ptr_next = {IW{1'b0}};
    if (w_rr_idx == IW'(NUM_REQ-1)) begin
      w_ptr_next = (PRIO0 != 0) ? IW'(1) : {IW{1'b0}};
    end else begin
      w_ptr_next = w_rr_idx + IW'(1);
    end
  end

  // Round-robin pointer moves only on round-robin grants.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= {IW{1'b0}};
    end else if (w_rr_fire) begin
      r_ptr <= w_ptr_next;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Stage 1: launch the ROM read and record its owner; address holds on idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_ena_n   <= 1'b1;
      r_rom_address <= {AW{1'b0}};
      r_s1_v        <= 1'b0;
      r_s1_id       <= {IW{1'b0}};
    end else if (w_any_grant) begin
      r_rom_ena_n   <= 1'b0;
      r_rom_address <= w_win_addr;
      r_s1_v        <= 1'b1;
      r_s1_id       <= w_win_idx;
    end else begin
      r_rom_ena_n   <= 1'b1;
      r_rom_address <= r_rom_address;
      r_s1_v        <= 1'b0;
      r_s1_id       <= r_s1_id;
    end
  end

  // Stage 2: owner follows the read while the ROM registers its output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_v  <= 1'b0;
      r_s2_id <= {IW{1'b0}};
    end else begin
      r_s2_v  <= r_s1_v;
      r_s2_id <= r_s1_id;
    end
  end

  // Stage 3: capture ROM data only for tracked reads, so a floating bus is never sampled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= {NUM_REQ{1'b0}};
      r_rd_data  <= {DW{1'b0}};
    end else if (r_s2_v) begin
      r_rd_valid <= NUM_REQ'(id_to_onehot(3'(r_s2_id)));
      r_rd_data  <= bus.rom_q;
    end else begin
      r_rd_valid <= {NUM_REQ{1'b0}};
      r_rd_data  <= r_rd_data;
    end
  end

  assign bus.ack         = w_grant;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_data     = r_rd_data;
  assign bus.rom_ena_n   = r_rom_ena_n;
  assign bus.rom_address = r_rom_address;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: one instance with requester-0 priority,
// one pure round-robin instance, each with its own behavioural sprom.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  logic clock;
  logic rst_p_n;
  logic rst_r_n;
  int   total;
  int   bad;

  logic [2:0]  m_v   [2][3];
  logic [14:0] m_a   [2][3];
  logic [7:0]  m_last[2];

  rom_arbiter_if #(.NUM_REQ(3), .AW(15), .DW(8)) bp ();
  rom_arbiter_if #(.NUM_REQ(3), .AW(15), .DW(8)) br ();

  rom_arbiter #(.NUM_REQ(3), .AW(15), .DW(8), .PRIO0(1)) dut_p (
    .clock   (clock),
    .reset_n (rst_p_n),
    .bus     (bp.slave)
  );

  rom_arbiter #(.NUM_REQ(3), .AW(15), .DW(8), .PRIO0(0)) dut_r (
    .clock   (clock),
    .reset_n (rst_r_n),
    .bus     (br.slave)
  );

  function automatic logic [7:0] romf(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural sprom for each instance: registered read, z when disabled.
  always_ff @(posedge clock) begin
    if (!bp.rom_ena_n) bp.rom_q <= romf(bp.rom_address);
    else               bp.rom_q <= 8'bz;
    if (!br.rom_ena_n) br.rom_q <= romf(br.rom_address);
    else               br.rom_q <= 8'bz;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model(input int d);
    for (int s = 0; s < 3; s++) begin
      m_v[d][s] = 3'b000;
      m_a[d][s] = 15'h0000;
    end
    m_last[d] = 8'h00;
  endtask

  // One cycle: drive req, check ack, clock, then check ROM side and returns.
  task automatic step(input int d, input logic [2:0] rq, input logic [2:0] exp_ack);
    logic [2:0]  ack_o;
    logic [44:0] ad;
    logic [14:0] wa;
    logic        ena_o;
    logic [14:0] ra_o;
    logic [2:0]  rv_o;
    logic [7:0]  rd_o;
    if (d == 0) bp.req = rq; else br.req = rq;
    #1;
    ack_o = (d == 0) ? bp.ack : br.ack;
    ad    = (d == 0) ? bp.addr : br.addr;
    chk((d == 0) ? "p_ack" : "r_ack", {29'd0, ack_o}, {29'd0, exp_ack});
    wa = 15'h0000;
    for (int j = 0; j < 3; j++) begin
      if (exp_ack[j]) wa = ad[j*15 +: 15];
    end
    tick;
    m_v[d][2] = m_v[d][1]; m_a[d][2] = m_a[d][1];
    m_v[d][1] = m_v[d][0]; m_a[d][1] = m_a[d][0];
    m_v[d][0] = exp_ack;   m_a[d][0] = wa;
    ena_o = (d == 0) ? bp.rom_ena_n   : br.rom_ena_n;
    ra_o  = (d == 0) ? bp.rom_address : br.rom_address;
    rv_o  = (d == 0) ? bp.rd_valid    : br.rd_valid;
    rd_o  = (d == 0) ? bp.rd_data     : br.rd_data;
    chk("rom_ena_n", {31'd0, ena_o}, {31'd0, (exp_ack == 3'b000)});
    if (exp_ack != 3'b000) chk("rom_address", {17'd0, ra_o}, {17'd0, wa});
    chk("rd_valid", {29'd0, rv_o}, {29'd0, m_v[d][2]});
    if (m_v[d][2] != 3'b000) m_last[d] = romf(m_a[d][2]);
    chk("rd_data", {24'd0, rd_o}, {24'd0, m_last[d]});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_p_n = 1'b0;
    rst_r_n = 1'b0;
    bp.req  = 3'b111;
    br.req  = 3'b111;
    bp.addr = '0;
    br.addr = '0;
    clear_model(0);
    clear_model(1);

    // Reset state, with requests pending
    tick;
    chk("rst_p_ack", {29'd0, bp.ack}, 32'd0);
    chk("rst_r_ack", {29'd0, br.ack}, 32'd0);
    chk("rst_ena_n", {31'd0, bp.rom_ena_n}, 32'd1);
    chk("rst_addr", {17'd0, bp.rom_address}, 32'd0);
    chk("rst_rd_valid", {29'd0, bp.rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, bp.rd_data}, 32'd0);
    bp.req  = 3'b000;
    br.req  = 3'b000;
    rst_p_n = 1'b1;
    rst_r_n = 1'b1;
    tick;

    // Single read by requester 1 (pointer 0 -> 2)
    bp.addr[1*15 +: 15] = 15'h1234;
    step(0, 3'b010, 3'b010);
    step(0, 3'b000, 3'b000);
    step(0, 3'b000, 3'b000);
    step(0, 3'b000, 3'b000);

    // Contention with priority: 0 wins while asserted, then 2/1 alternate
    bp.addr = {15'h0300, 15'h0200, 15'h0100};
    step(0, 3'b111, 3'b001);
    step(0, 3'b111, 3'b001);
    step(0, 3'b111, 3'b001);
    // Wrap: only 1 and 2 active, pointer skips 0
    step(0, 3'b110, 3'b100);
    step(0, 3'b110, 3'b010);
    step(0, 3'b110, 3'b100);
    step(0, 3'b110, 3'b010);
    step(0, 3'b110, 3'b100);
    step(0, 3'b110, 3'b010);
    step(0, 3'b000, 3'b000);
    step(0, 3'b000, 3'b000);
    step(0, 3'b000, 3'b000);

    // Idle gaps: rd_data holds while rom_q floats
    step(0, 3'b100, 3'b100);
    step(0, 3'b000, 3'b000);
    bp.addr[2*15 +: 15] = 15'h4567;
    step(0, 3'b100, 3'b100);
    step(0, 3'b000, 3'b000);
    step(0, 3'b000, 3'b000);
    step(0, 3'b000, 3'b000);

    // Pure round-robin streaming with incrementing addresses
    br.addr = {15'h0030, 15'h0020, 15'h0010};
    for (int i = 0; i < 6; i++) begin
      step(1, 3'b111, 3'(1 << (i % 3)));
      br.addr[(i % 3)*15 +: 15] = br.addr[(i % 3)*15 +: 15] + 15'd1;
    end
    step(1, 3'b000, 3'b000);
    step(1, 3'b000, 3'b000);
    step(1, 3'b000, 3'b000);

    // Reset one cycle after two back-to-back acks
    step(1, 3'b111, 3'b001);
    step(1, 3'b111, 3'b010);
    rst_r_n = 1'b0;
    clear_model(1);
    #1;
    chk("mid_rst_ack", {29'd0, br.ack}, 32'd0);
    chk("mid_rst_ena_n", {31'd0, br.rom_ena_n}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_rd_valid", {29'd0, br.rd_valid}, 32'd0);
      tick;
    end
    chk("mid_rst_rd_data", {24'd0, br.rd_data}, 32'd0);
    rst_r_n = 1'b1;
    // Pointer back at 0: requester 0 wins first
    step(1, 3'b111, 3'b001);
    step(1, 3'b000, 3'b000);
    step(1, 3'b000, 3'b000);
    step(1, 3'b000, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
